// File: rtl/button_event_gen.sv
// ---------------------------------------------------------------------------
// button_event_gen
//
// Purpose:
//   Converts the clean, debounced level of one button into single-cycle UI
//   events for the calendar control FSM:
//     - short press : released before the long-press threshold
//     - long press  : threshold reached while still held
//     - auto-repeat : periodic pulse while held after a long press (optional)
//   All outputs are registered.
//
// Configuration macro:
//   AUTO_REPEAT_EN - when defined, repeat_pulse fires every REPEAT_CYCLES
//                    after long_press while the button stays held. When
//                    undefined, repeat_pulse is constant 0 and REPEAT_CYCLES
//                    has no effect.
//
// Parameters:
//   LONG_CYCLES    hold time in clk cycles that qualifies a long press (>=2)
//   REPEAT_CYCLES  auto-repeat period in clk cycles (>=2)
//   CNT_W          hold counter width, must hold max(LONG,REPEAT)-1
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   temiz_sinyal  in   debounced button level, 1 = pressed
//   enable        in   1 = detect events, 0 = force idle
//   short_press   out  1-cycle pulse on release before the threshold
//   long_press    out  1-cycle pulse when the threshold is reached
//   repeat_pulse  out  1-cycle auto-repeat pulse (AUTO_REPEAT_EN only)
//   held          out  level, 1 while a press is being tracked
// ---------------------------------------------------------------------------
module button_event_gen #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic temiz_sinyal,
  input  logic enable,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             lvl_q;
  logic             rise;

  // Only a fresh 0->1 transition starts a press; a level that is already
  // high (after enable returns, for example) never does.
  assign rise = temiz_sinyal & ~lvl_q;

  // Previous-level register keeps tracking even while enable is low, so a
  // button held across re-enable is not mistaken for a new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= temiz_sinyal;
    end
  end

  // Press-tracking FSM. Pulses default to 0 each cycle so every event is a
  // single-cycle pulse; held mirrors whether the next state is not IDLE.
  // Release is tested before the threshold, so a release landing on the
  // threshold edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        counter <= '0;
        held    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= '0;
            if (rise) begin
              state <= PRESSED;
              held  <= 1'b1;
            end else begin
              held  <= 1'b0;
            end
          end
          PRESSED: begin
            if (!temiz_sinyal) begin
              state       <= IDLE;
              counter     <= '0;
              short_press <= 1'b1;
              held        <= 1'b0;
            end else if (counter == LONG_LAST) begin
              state      <= LONG_HELD;
              counter    <= '0;
              long_press <= 1'b1;
              held       <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
              held    <= 1'b1;
            end
          end
          LONG_HELD: begin
            if (!temiz_sinyal) begin
              state   <= IDLE;
              counter <= '0;
              held    <= 1'b0;
            end else begin
              held <= 1'b1;
`ifdef AUTO_REPEAT_EN
              // Counter wraps at the repeat period, so it never runs past
              // its terminal value.
              if (counter == REPEAT_LAST) begin
                counter      <= '0;
                repeat_pulse <= 1'b1;
              end else begin
                counter <= counter + 1'b1;
              end
`else
              // Without auto-repeat the counter parks at zero while held.
              counter <= (REPEAT_LAST == '0) ? '0 : '0;
`endif
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
            held    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// ---------------------------------------------------------------------------
// tb_button_event_gen
//
// Self-checking bench for button_event_gen with LONG_CYCLES=8,
// REPEAT_CYCLES=4. A press-age model predicts every output each cycle and a
// compare process checks the DUT against it on every falling edge; directed
// scenarios add literal expectations at hand-computed edges. Works with or
// without AUTO_REPEAT_EN defined.
// ---------------------------------------------------------------------------
module tb_button_event_gen;

  localparam int L = 8;
  localparam int R = 4;
`ifdef AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic temiz_sinyal;
  logic enable;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic held;

  int n_compared;
  int n_failed;

  // model state
  bit m_active;
  bit m_prev;
  int m_start;
  int cyc;
  bit exp_sp, exp_lp, exp_rp, exp_held;

  button_event_gen #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .temiz_sinyal(temiz_sinyal),
    .enable      (enable),
    .short_press (short_press),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Press-age model: a press starts on a rising level; its age in edges
  // decides the event. Release at age <= L is a short press, age == L while
  // high is the long press, and every R edges beyond L is a repeat.
  initial begin
    m_active = 0; m_prev = 0; m_start = 0; cyc = 0;
    exp_sp = 0; exp_lp = 0; exp_rp = 0; exp_held = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_active = 0; m_prev = 0;
        exp_sp = 0; exp_lp = 0; exp_rp = 0; exp_held = 0;
      end else begin
        bit r;
        int age;
        cyc++;
        r = temiz_sinyal && !m_prev;
        m_prev = temiz_sinyal;
        exp_sp = 0; exp_lp = 0; exp_rp = 0;
        if (!enable) begin
          m_active = 0;
        end else if (m_active) begin
          age = cyc - m_start;
          if (!temiz_sinyal) begin
            m_active = 0;
            if (age <= L) exp_sp = 1;
          end else if (age == L) begin
            exp_lp = 1;
          end else if (REP_ON && age > L && ((age - L) % R) == 0) begin
            exp_rp = 1;
          end
        end else if (r) begin
          m_active = 1;
          m_start  = cyc;
        end
        exp_held = m_active;
      end
    end
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model.short_press",  short_press,  exp_sp);
      checkOutput("model.long_press",   long_press,   exp_lp);
      checkOutput("model.repeat_pulse", repeat_pulse, exp_rp);
      checkOutput("model.held",         held,         exp_held);
    end
  end

  // Drive inputs just after a falling edge and hold them for n rising edges;
  // returns at the falling edge after the last of those rising edges.
  task automatic applyStimulus(input logic lvl, input logic en, input int n);
    temiz_sinyal = lvl;
    enable       = en;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    reset        = 1'b1;
    temiz_sinyal = 1'b0;
    enable       = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset.short_press",  short_press,  1'b0);
    checkOutput("reset.long_press",   long_press,   1'b0);
    checkOutput("reset.repeat_pulse", repeat_pulse, 1'b0);
    checkOutput("reset.held",         held,         1'b0);
    reset = 1'b0;
    applyStimulus(0, 1, 3);

    // Short press: high for edges 0..2, released at edge 3.
    $display("[TB] short press");
    applyStimulus(1, 1, 3);
    checkOutput("short.held_edge2", held, 1'b1);
    applyStimulus(0, 1, 1);
    checkOutput("short.pulse_edge3", short_press, 1'b1);
    checkOutput("short.no_long",     long_press,  1'b0);
    checkOutput("short.held_drop",   held,        1'b0);
    applyStimulus(0, 1, 3);

    // Long press with repeat: high for edges 0..20, released at 21.
    $display("[TB] long press");
    applyStimulus(1, 1, 8);
    checkOutput("long.none_edge7", long_press, 1'b0);
    applyStimulus(1, 1, 1);
    checkOutput("long.pulse_edge8", long_press, 1'b1);
    applyStimulus(1, 1, 4);
    checkOutput("long.repeat_edge12", repeat_pulse, REP_ON);
    applyStimulus(1, 1, 8);
    checkOutput("long.repeat_edge20", repeat_pulse, REP_ON);
    applyStimulus(0, 1, 1);
    checkOutput("long.no_short_release", short_press, 1'b0);
    checkOutput("long.held_drop",        held,        1'b0);
    applyStimulus(0, 1, 3);

    // Boundary: release sampled at edge 8 wins over the threshold.
    $display("[TB] boundary");
    applyStimulus(1, 1, 8);
    applyStimulus(0, 1, 1);
    checkOutput("bound.short_edge8", short_press, 1'b1);
    checkOutput("bound.no_long",     long_press,  1'b0);
    applyStimulus(0, 1, 3);

    // Enable gating, then re-enable while still held.
    $display("[TB] enable gating");
    applyStimulus(1, 1, 4);
    applyStimulus(1, 0, 1);
    checkOutput("en.held_drop", held, 1'b0);
    applyStimulus(1, 0, 10);
    applyStimulus(1, 1, 12);
    checkOutput("en.reenable_no_held", held, 1'b0);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 1, 1);
    checkOutput("en.repress_held", held, 1'b1);
    applyStimulus(0, 1, 1);
    checkOutput("en.repress_short", short_press, 1'b1);
    applyStimulus(0, 1, 3);

    // Asynchronous reset before edge 5 of a hold.
    $display("[TB] reset mid-hold");
    applyStimulus(1, 1, 5);
    checkOutput("rst.held_before", held, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rst.held_now",  held,        1'b0);
    checkOutput("rst.long_now",  long_press,  1'b0);
    checkOutput("rst.short_now", short_press, 1'b0);
    temiz_sinyal = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1, 12);
    checkOutput("rst.quiet_held", held, 1'b0);
    applyStimulus(1, 1, 2);
    applyStimulus(0, 1, 1);
    checkOutput("rst.new_short", short_press, 1'b1);
    applyStimulus(0, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
